// File: rtl/fetch_prefetch_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
// Requests use req/gnt. Responses use rvalid and return in request order.
//   ImemReq     fetch request (master -> slave)
//   ImemAddr    word-aligned fetch address (master -> slave)
//   ImemGnt     request accepted this cycle (slave -> master)
//   ImemRValid  response word valid (slave -> master)
//   ImemRData   response instruction word (slave -> master)
interface fetch_prefetch_if #(
   parameter int unsigned XLEN = 32
);
   logic            ImemReq;
   logic [XLEN-1:0] ImemAddr;
   logic            ImemGnt;
   logic            ImemRValid;
   logic [31:0]     ImemRData;

   modport master (
      output ImemReq,
      output ImemAddr,
      input  ImemGnt,
      input  ImemRValid,
      input  ImemRData
   );

   modport slave (
      input  ImemReq,
      input  ImemAddr,
      output ImemGnt,
      output ImemRValid,
      output ImemRData
   );
endinterface

// File: rtl/fetch_prefetch.sv
// Prefetching IF stage. PC generation is decoupled from a variable-latency instruction memory.
// The stage issues in-order fetches on the imem bus. It buffers returned words with their PCs in
// a DEPTH-entry queue and presents the head entry to ID under a valid/ready handshake. An EX
// redirect flushes the queue and squashes responses that are still in flight.
//   clk          clock, all state on posedge
//   rst          synchronous active-high reset
//   PCSrcE       redirect request from EX
//   PCTargetE    redirect target (low two bits ignored)
//   InstrReadyD  ID accepts the head entry this cycle
//   InstrValidF  head entry valid
//   InstrF       head instruction word
//   PCF          PC of head instruction
//   PCPlus4F     PCF + 4
//   imem         instruction-memory bus (master side)
module fetch_prefetch #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               PCSrcE,
   input  logic [XLEN-1:0]    PCTargetE,
   input  logic               InstrReadyD,
   output logic               InstrValidF,
   output logic [31:0]        InstrF,
   output logic [XLEN-1:0]    PCF,
   output logic [XLEN-1:0]    PCPlus4F,
   fetch_prefetch_if.master   imem
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned SW = CW + 1;
   localparam int unsigned PW = $clog2(DEPTH);

   typedef logic [CW-1:0] cnt_t;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   // PC of the next response to be kept. Responses return in order and a redirect discards
   // everything older, so a simple incrementing counter tracks the matching grant address.
   logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
   cnt_t            count_q, count_d;
   cnt_t            outstanding_q, outstanding_d;
   cnt_t            drop_q, drop_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [31:0]     instr_mem_q [DEPTH];
   logic [XLEN-1:0] pc_mem_q [DEPTH];

   logic            credit_ok;
   logic            req;
   logic            grant;
   logic            rsp_keep;
   logic            rsp_drop;
   logic            enq;
   logic            deq;
   logic [SW-1:0]   drop_sum;
   logic            unused_tgt;

   assign unused_tgt = ^PCTargetE[1:0];

   always_comb begin
      credit_ok = (SW'(count_q) + SW'(outstanding_q)) < SW'(DEPTH);
      req       = credit_ok & ~PCSrcE & ~rst;
      grant     = req & imem.ImemGnt;
      rsp_keep  = imem.ImemRValid & (drop_q == '0) & (outstanding_q != '0);
      rsp_drop  = imem.ImemRValid & (drop_q != '0);
      enq       = rsp_keep & ~PCSrcE;

      InstrValidF = (count_q != '0) & ~PCSrcE;
      deq         = InstrValidF & InstrReadyD;
      InstrF      = instr_mem_q[rd_ptr_q];
      PCF         = pc_mem_q[rd_ptr_q];
      PCPlus4F    = PCF + XLEN'(4);

      imem.ImemReq  = req;
      imem.ImemAddr = fetch_pc_q;
   end

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      count_d       = count_q;
      outstanding_d = outstanding_q;
      drop_d        = drop_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      drop_sum      = '0;

      if (PCSrcE) begin
         // A response arriving this cycle retires one pending word before the rest are
         // converted to drops.
         drop_sum = SW'(drop_q) + SW'(outstanding_q) - SW'(rsp_keep | rsp_drop);
         drop_d   = (drop_sum > SW'(DEPTH)) ? cnt_t'(DEPTH) : drop_sum[CW-1:0];
         count_d       = '0;
         outstanding_d = '0;
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         fetch_pc_d    = {PCTargetE[XLEN-1:2], 2'b00};
         rsp_pc_d      = {PCTargetE[XLEN-1:2], 2'b00};
      end else begin
         count_d       = count_q + cnt_t'(enq) - cnt_t'(deq);
         outstanding_d = outstanding_q + cnt_t'(grant) - cnt_t'(rsp_keep);
         drop_d        = drop_q - cnt_t'(rsp_drop);
         if (grant) fetch_pc_d = fetch_pc_q + XLEN'(4);
         if (enq) begin
            rsp_pc_d = rsp_pc_q + XLEN'(4);
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         count_q       <= '0;
         outstanding_q <= '0;
         drop_q        <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_mem_q[i] <= '0;
            pc_mem_q[i]    <= '0;
         end
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         if (enq) begin
            instr_mem_q[wr_ptr_q] <= imem.ImemRData;
            pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
         end
      end
   end

   // A response with nothing pending is a memory protocol error. The logic above ignores it.
   rvalid_legal_a : assert property (@(posedge clk) disable iff (rst)
      !(imem.ImemRValid && (outstanding_q == '0) && (drop_q == '0)));

endmodule
